// File: rtl/ttt_game_ctrl_if.sv
// Move handshake between a player front-end and the tic-tac-toe sequencer.
// The master offers a cell index; the slave answers with ready and one-cycle ack/err pulses.
interface ttt_game_ctrl_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic       move_ack;
  logic       move_err;

  modport master (
    output move_valid, move_pos,
    input  move_ready, move_ack, move_err
  );

  modport slave (
    input  move_valid, move_pos,
    output move_ready, move_ack, move_err
  );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Two-player 3x3 tic-tac-toe sequencer: holds both occupancy boards, arbitrates moves,
// enforces a per-move timeout and latches the win/draw result after every move.

module ttt_win_check (
  input  logic [8:0] board,
  output logic       win
);
  assign win = (&board[2:0]) | (&board[5:3]) | (&board[8:6])
             | (board[0] & board[3] & board[6])
             | (board[1] & board[4] & board[7])
             | (board[2] & board[5] & board[8])
             | (board[0] & board[4] & board[8])
             | (board[2] & board[4] & board[6]);
endmodule

// state | meaning
// PLAY  | waiting for a move from turn's player; timer running
// CHECK | one cycle evaluating the board just written
// DONE  | result latched; only new_game leaves
module ttt_game_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter bit START_PLAYER   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 new_game,
  ttt_game_ctrl_if.slave       mv,
  output logic [8:0]           x_board,
  output logic [8:0]           o_board,
  output logic                 turn,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 timeout
);

  localparam logic [1:0] ST_PLAY  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam bit TIMER_ON = (TIMEOUT_CYCLES > 0);
  localparam int TW       = TIMER_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMER_ON ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          ack_q;
  logic          err_q;

  logic [8:0]    occupied;
  logic [15:0]   occ_ext;
  logic [8:0]    move_bit;
  logic          legal;
  logic          illegal;
  logic          expire;
  logic          win_x;
  logic          win_o;
  logic          mover_win;

  ttt_win_check u_win_x (.board(x_board), .win(win_x));
  ttt_win_check u_win_o (.board(o_board), .win(win_o));

  assign occupied  = x_board | o_board;
  // Indices 9..15 read as occupied so one lookup covers both rejection causes.
  assign occ_ext   = {7'h7F, occupied};
  assign move_bit  = 9'd1 << mv.move_pos;
  assign legal     = (state == ST_PLAY) & mv.move_valid & ~occ_ext[mv.move_pos];
  assign illegal   = (state == ST_PLAY) & mv.move_valid &  occ_ext[mv.move_pos];
  assign expire    = TIMER_ON & (timer == TIMER_LAST);
  assign mover_win = turn ? win_o : win_x;

  assign mv.move_ready = (state == ST_PLAY);
  assign mv.move_ack   = ack_q;
  assign mv.move_err   = err_q;
  assign game_over     = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_PLAY;
      x_board <= '0;
      o_board <= '0;
      turn    <= START_PLAYER;
      timer   <= '0;
      winner  <= 2'b00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      timeout <= 1'b0;
      if (new_game) begin
        state   <= ST_PLAY;
        x_board <= '0;
        o_board <= '0;
        turn    <= START_PLAYER;
        timer   <= '0;
        winner  <= 2'b00;
      end else begin
        case (state)
          ST_PLAY: begin
            if (legal) begin
              if (turn) o_board <= o_board | move_bit;
              else      x_board <= x_board | move_bit;
              ack_q <= 1'b1;
              state <= ST_CHECK;
            end else begin
              err_q <= illegal;
              if (expire) begin
                turn    <= ~turn;
                timer   <= '0;
                timeout <= 1'b1;
              end else if (TIMER_ON && !illegal) begin
                timer <= timer + 1'b1;
              end
            end
          end
          ST_CHECK: begin
            if (mover_win) begin
              winner <= turn ? 2'b10 : 2'b01;
              state  <= ST_DONE;
            end else if (&occupied) begin
              winner <= 2'b11;
              state  <= ST_DONE;
            end else begin
              turn  <= ~turn;
              timer <= '0;
              state <= ST_PLAY;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_PLAY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: per-move vector table plus hand sequences
// for CHECK-cycle behaviour, async reset and the move timeout.
module tb_ttt_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic new_game;
  logic ng_t;

  logic [8:0] xb, ob, xb_t, ob_t;
  logic       trn, over, to, trn_t, over_t, to_t;
  logic [1:0] win, win_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ttt_game_ctrl_if mif ();
  ttt_game_ctrl_if tif ();

  ttt_game_ctrl #(.TIMEOUT_CYCLES(1000), .START_PLAYER(1'b0)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .mv(mif),
    .x_board(xb), .o_board(ob), .turn(trn), .game_over(over),
    .winner(win), .timeout(to)
  );

  ttt_game_ctrl #(.TIMEOUT_CYCLES(8), .START_PLAYER(1'b0)) dut_t (
    .clk(clk), .reset(reset), .new_game(ng_t), .mv(tif),
    .x_board(xb_t), .o_board(ob_t), .turn(trn_t), .game_over(over_t),
    .winner(win_t), .timeout(to_t)
  );

  typedef struct {
    logic       ng;
    logic       vld;
    logic [3:0] pos;
    logic       ack;
    logic       err;
    logic [8:0] x;
    logic [8:0] o;
    logic       trn;
    logic       over;
    logic [1:0] win;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic ng, input logic vld, input logic [3:0] pos,
                     input logic ack, input logic err, input logic [8:0] x,
                     input logic [8:0] o, input logic t, input logic ov,
                     input logic [1:0] w);
    vec_t v;
    v.ng = ng; v.vld = vld; v.pos = pos; v.ack = ack; v.err = err;
    v.x = x; v.o = o; v.trn = t; v.over = ov; v.win = w;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // X wins on the top row; a later move in DONE is ignored
    add(0,1,4'd0, 1,0, 9'h001,9'h000, 1,0,2'b00);
    add(0,1,4'd3, 1,0, 9'h001,9'h008, 0,0,2'b00);
    add(0,1,4'd1, 1,0, 9'h003,9'h008, 1,0,2'b00);
    add(0,1,4'd4, 1,0, 9'h003,9'h018, 0,0,2'b00);
    add(0,1,4'd2, 1,0, 9'h007,9'h018, 0,1,2'b01);
    add(0,1,4'd5, 0,0, 9'h007,9'h018, 0,1,2'b01);
    // new_game wins over a simultaneous move
    add(1,1,4'd4, 0,0, 9'h000,9'h000, 0,0,2'b00);
    // occupied cell, then a good move
    add(0,1,4'd4, 1,0, 9'h010,9'h000, 1,0,2'b00);
    add(0,1,4'd4, 0,1, 9'h010,9'h000, 1,0,2'b00);
    add(0,1,4'd0, 1,0, 9'h010,9'h001, 0,0,2'b00);
    // out-of-range indices
    add(0,1,4'd9,  0,1, 9'h010,9'h001, 0,0,2'b00);
    add(0,1,4'd15, 0,1, 9'h010,9'h001, 0,0,2'b00);
    // draw
    add(1,0,4'd0, 0,0, 9'h000,9'h000, 0,0,2'b00);
    add(0,1,4'd0, 1,0, 9'h001,9'h000, 1,0,2'b00);
    add(0,1,4'd1, 1,0, 9'h001,9'h002, 0,0,2'b00);
    add(0,1,4'd2, 1,0, 9'h005,9'h002, 1,0,2'b00);
    add(0,1,4'd4, 1,0, 9'h005,9'h012, 0,0,2'b00);
    add(0,1,4'd3, 1,0, 9'h00D,9'h012, 1,0,2'b00);
    add(0,1,4'd5, 1,0, 9'h00D,9'h032, 0,0,2'b00);
    add(0,1,4'd7, 1,0, 9'h08D,9'h032, 1,0,2'b00);
    add(0,1,4'd6, 1,0, 9'h08D,9'h072, 0,0,2'b00);
    add(0,1,4'd8, 1,0, 9'h18D,9'h072, 0,1,2'b11);
    // O wins on the middle row
    add(1,0,4'd0, 0,0, 9'h000,9'h000, 0,0,2'b00);
    add(0,1,4'd0, 1,0, 9'h001,9'h000, 1,0,2'b00);
    add(0,1,4'd3, 1,0, 9'h001,9'h008, 0,0,2'b00);
    add(0,1,4'd1, 1,0, 9'h003,9'h008, 1,0,2'b00);
    add(0,1,4'd4, 1,0, 9'h003,9'h018, 0,0,2'b00);
    add(0,1,4'd8, 1,0, 9'h103,9'h018, 1,0,2'b00);
    add(0,1,4'd5, 1,0, 9'h103,9'h038, 1,1,2'b10);
    add(1,0,4'd0, 0,0, 9'h000,9'h000, 0,0,2'b00);

    reset = 1'b1; new_game = 1'b0; ng_t = 1'b0;
    mif.move_valid = 1'b0; mif.move_pos = 4'd0;
    tif.move_valid = 1'b0; tif.move_pos = 4'd0;
    #3;
    chk("rst_ready", mif.move_ready, 1);
    chk("rst_x", xb, 0);
    chk("rst_o", ob, 0);
    chk("rst_turn", trn, 0);
    chk("rst_over", over, 0);
    chk("rst_winner", win, 0);
    chk("rst_ack", mif.move_ack, 0);
    chk("rst_err", mif.move_err, 0);
    chk("rst_timeout", to, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      new_game = vecs[i].ng;
      mif.move_valid = vecs[i].vld;
      mif.move_pos = vecs[i].pos;
      step();
      new_game = 1'b0;
      mif.move_valid = 1'b0;
      chk($sformatf("v%0d_ack", i), mif.move_ack, vecs[i].ack);
      chk($sformatf("v%0d_err", i), mif.move_err, vecs[i].err);
      step();
      chk($sformatf("v%0d_x", i), xb, vecs[i].x);
      chk($sformatf("v%0d_o", i), ob, vecs[i].o);
      chk($sformatf("v%0d_turn", i), trn, vecs[i].trn);
      chk($sformatf("v%0d_over", i), over, vecs[i].over);
      chk($sformatf("v%0d_winner", i), win, vecs[i].win);
    end

    // move_valid held through CHECK must be ignored
    mif.move_valid = 1'b1; mif.move_pos = 4'd0;
    step();
    chk("chk_ack", mif.move_ack, 1);
    chk("chk_ready", mif.move_ready, 0);
    mif.move_pos = 4'd4;
    step();
    chk("chk_ign_ack", mif.move_ack, 0);
    chk("chk_ign_err", mif.move_err, 0);
    mif.move_valid = 1'b0;
    step();
    chk("chk_ign_x", xb, 9'h001);
    chk("chk_ign_o", ob, 9'h000);
    chk("chk_ign_turn", trn, 1);

    // async reset while in CHECK
    mif.move_valid = 1'b1; mif.move_pos = 4'd4;
    step();
    mif.move_valid = 1'b0;
    chk("mid_ack", mif.move_ack, 1);
    chk("mid_ready", mif.move_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_x", xb, 0);
    chk("arst_o", ob, 0);
    chk("arst_ack", mif.move_ack, 0);
    chk("arst_ready", mif.move_ready, 1);
    chk("arst_turn", trn, 0);
    chk("arst_over", over, 0);
    chk("arst_winner", win, 0);
    @(negedge clk);
    reset = 1'b0;

    // timeout after 8 idle cycles, and timer cleared afterwards
    ng_t = 1'b1;
    step();
    ng_t = 1'b0;
    repeat (7) step();
    chk("to_early", to_t, 0);
    chk("to_early_turn", trn_t, 0);
    step();
    chk("to_pulse", to_t, 1);
    chk("to_turn", trn_t, 1);
    step();
    chk("to_pulse_end", to_t, 0);
    repeat (6) step();
    chk("to2_early", to_t, 0);
    step();
    chk("to2_pulse", to_t, 1);
    chk("to2_turn", trn_t, 0);

    // legal move on the expiry cycle beats the timeout
    ng_t = 1'b1;
    step();
    ng_t = 1'b0;
    repeat (7) step();
    tif.move_valid = 1'b1; tif.move_pos = 4'd0;
    step();
    tif.move_valid = 1'b0;
    chk("tm_ack", tif.move_ack, 1);
    chk("tm_no_to", to_t, 0);
    chk("tm_turn_hold", trn_t, 0);
    step();
    chk("tm_turn", trn_t, 1);
    chk("tm_x", xb_t, 9'h001);
    repeat (7) step();
    chk("tm_to_early", to_t, 0);
    step();
    chk("tm_to_pulse", to_t, 1);
    chk("tm_to_turn", trn_t, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
